serial_add: RTL

Parametrised multi-cycle adder/subtractor: it adds or subtracts two WIDTH-bit operands DIGIT bits per clock. A single DIGIT-bit ripple digit adder is reused across cycles, with a registered carry between digits. It sits in the arith library as the area-cheap alternative to a full-width ripple adder. Exposes a start/busy/done handshake, carry-out and signed overflow.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_add_digit_add.sv | 28 ++
 rtl/serial_add.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM encoding and sizing helper for the digit-serial adder
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Step counter width: clog2 of the cycle count, never narrower than one bit.
   function automatic int step_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_digit_add.sv
// rtl/serial_add_digit_add.sv - combinational DIGIT-bit ripple adder, exposes carry into its top bit
module serial_add_digit_add #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_top
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = c[DIGIT];
   assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_add.sv
// rtl/serial_add.sv - multi-cycle adder/subtractor, DIGIT bits per clock through one reused digit adder
module serial_add
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov
);

   localparam int N  = WIDTH / DIGIT;
   localparam int SW = step_width(N);
   localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

   if ((WIDTH < 1) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("serial_add: DIGIT must be >= 1 and divide WIDTH exactly");
   end

   state_t           state, state_n;
   logic             load, run, last;
   logic [WIDTH-1:0] a_q, b_q, acc;
   logic             carry;
   logic [SW-1:0]    step;

   logic [DIGIT-1:0]       d_sum;
   logic                   d_cout, d_ctop;
   logic [WIDTH+DIGIT-1:0] acc_cat;
   logic [WIDTH-1:0]       acc_next;

   serial_add_digit_add #(.DIGIT(DIGIT)) u_digit (
      .a     (a_q[DIGIT-1:0]),
      .b     (b_q[DIGIT-1:0]),
      .cin   (carry),
      .sum   (d_sum),
      .cout  (d_cout),
      .c_top (d_ctop)
   );

   // New digit enters at the top; after N steps the first digit has reached bit 0.
   assign acc_cat  = {d_sum, acc};
   assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

   always_comb begin
      state_n = state;
      load    = 1'b0;
      run     = 1'b0;
      last    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            run = 1'b1;
            if (step == LAST_STEP) begin
               last    = 1'b1;
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               load    = 1'b1;
               state_n = ST_RUN;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      busy = (state == ST_RUN);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         step  <= '0;
         s     <= '0;
         co    <= 1'b0;
         ov    <= 1'b0;
      end else if (load) begin
         // Subtraction runs as a + ~b + ~ci, so the borrow-in is inverted into the carry.
         a_q   <= a;
         b_q   <= sub ? ~b : b;
         carry <= ci ^ sub;
         acc   <= '0;
         step  <= '0;
      end else if (run) begin
         a_q   <= a_q >> DIGIT;
         b_q   <= b_q >> DIGIT;
         acc   <= acc_next;
         carry <= d_cout;
         step  <= step + SW'(1);
         if (last) begin
            s  <= acc_next;
            co <= d_cout;
            ov <= d_ctop ^ d_cout;
         end
      end
   end

endmodule
